// File: rtl/ipsxe_fft_spectrum_chk_pkg.sv
// Shared definitions for the FFT spectrum checker: state encoding and
// elaboration-time width helpers.
package ipsxe_fft_spectrum_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int byte_round_f(input int width);
        return ((width + 7) / 8) * 8;
    endfunction

endpackage

// File: rtl/ipsxe_fft_spectrum_dpram.sv
// Simple dual-port spectrum RAM: one write port, one registered read port.
// The address MSB selects the ping-pong bank.
module ipsxe_fft_spectrum_dpram #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 17
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] mem_q [0:(1 << ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage is never reset so a mid-frame reset leaves spectra intact.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        rdata_d = mem_q[i_raddr];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/ipsxe_fft_spectrum_chk.sv
// FFT output sink: frame check, |re|+|im| magnitude, ping-pong spectrum
// store, peak-bin report and good-frame counting for a test run.
module ipsxe_fft_spectrum_chk
    import ipsxe_fft_spectrum_chk_pkg::*;
#(
    parameter int LOG2_FFT_LEN   = 8,
    parameter int OUTPUT_WIDTH   = 16,
    parameter int TEST_FRAME_NUM = 10,
    parameter int PEAK_SKIP_DC   = 1,
    localparam int DATAOUT_WIDTH = byte_round_f(OUTPUT_WIDTH),
    localparam int MAG_WIDTH     = OUTPUT_WIDTH + 1,
    localparam int CNT_WIDTH     = clog2_f(TEST_FRAME_NUM + 1)
) (
    input  logic                       i_aclk,
    input  logic                       i_areset,
    input  logic                       i_aclken,
    output logic                       o_axi4s_data_tready,
    input  logic                       i_axi4s_data_tvalid,
    input  logic [2*DATAOUT_WIDTH-1:0] i_axi4s_data_tdata,
    input  logic                       i_axi4s_data_tlast,
    input  logic                       i_start_test,
    output logic                       o_chk_finished,
    output logic                       o_frame_err,
    output logic [CNT_WIDTH-1:0]       o_frm_cnt,
    output logic                       o_bank_sel,
    input  logic [LOG2_FFT_LEN-1:0]    i_rd_addr,
    output logic [MAG_WIDTH-1:0]       o_rd_data,
    output logic [LOG2_FFT_LEN-1:0]    o_peak_bin,
    output logic [MAG_WIDTH-1:0]       o_peak_mag
);

    localparam logic [LOG2_FFT_LEN-1:0] BIN_LAST  = {LOG2_FFT_LEN{1'b1}};
    localparam logic [LOG2_FFT_LEN-1:0] BIN_ZERO  = {LOG2_FFT_LEN{1'b0}};
    localparam logic [LOG2_FFT_LEN-1:0] BIN_ONE   = LOG2_FFT_LEN'(1);
    localparam logic [LOG2_FFT_LEN-1:0] PEAK_INIT = LOG2_FFT_LEN'((PEAK_SKIP_DC != 0) ? 1 : 0);
    localparam logic [OUTPUT_WIDTH-1:0] ONE_W     = OUTPUT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]    CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]    FRM_TGT   = CNT_WIDTH'(TEST_FRAME_NUM);

    state_e                  state_q, state_d;
    logic                    tready_q, tready_d;
    logic [LOG2_FFT_LEN-1:0] bin_q, bin_d;
    logic                    err_q, err_d;
    logic                    s1_vld_q, s1_vld_d, s1_good_q, s1_good_d, s1_bad_q, s1_bad_d;
    logic [OUTPUT_WIDTH-1:0] s1_re_q, s1_re_d, s1_im_q, s1_im_d;
    logic [LOG2_FFT_LEN-1:0] s1_bin_q, s1_bin_d;
    logic                    s2_vld_q, s2_vld_d, s2_good_q, s2_good_d, s2_bad_q, s2_bad_d;
    logic [MAG_WIDTH-1:0]    s2_mag_q, s2_mag_d;
    logic [LOG2_FFT_LEN-1:0] s2_bin_q, s2_bin_d;
    logic [LOG2_FFT_LEN-1:0] trk_bin_q, trk_bin_d, res_bin_q, res_bin_d;
    logic [MAG_WIDTH-1:0]    trk_mag_q, trk_mag_d, res_mag_q, res_mag_d;
    logic                    cmt_q, cmt_d, bank_q, bank_d, fin_q, fin_d;
    logic [LOG2_FFT_LEN-1:0] peak_bin_q, peak_bin_d;
    logic [MAG_WIDTH-1:0]    peak_mag_q, peak_mag_d;
    logic [CNT_WIDTH-1:0]    frm_cnt_q, frm_cnt_d;
    logic [OUTPUT_WIDTH-1:0] re_s, im_s;
    logic                    accept_s, at_last_s, cand_upd_s, we_s, wr_bank_s;

    // Beat acceptance, framing check and stage-1 absolute values.
    always_comb begin
        re_s      = i_axi4s_data_tdata[OUTPUT_WIDTH-1:0];
        im_s      = i_axi4s_data_tdata[DATAOUT_WIDTH +: OUTPUT_WIDTH];
        accept_s  = i_axi4s_data_tvalid & tready_q;
        at_last_s = (bin_q == BIN_LAST);
        bin_d     = bin_q;
        err_d     = err_q;
        s1_vld_d  = 1'b0;
        s1_good_d = 1'b0;
        s1_bad_d  = 1'b0;
        s1_bin_d  = bin_q;
        s1_re_d   = re_s[OUTPUT_WIDTH-1] ? (~re_s + ONE_W) : re_s;
        s1_im_d   = im_s[OUTPUT_WIDTH-1] ? (~im_s + ONE_W) : im_s;
        if (i_start_test) begin
            bin_d = BIN_ZERO;
            err_d = 1'b0;
        end else if (accept_s) begin
            s1_vld_d = 1'b1;
            if (i_axi4s_data_tlast) begin
                s1_good_d = at_last_s;
                s1_bad_d  = ~at_last_s;
                bin_d     = BIN_ZERO;
            end else begin
                s1_bad_d = at_last_s;
                bin_d    = bin_q + BIN_ONE;
            end
            err_d = err_q | s1_bad_d;
        end else begin
            bin_d = bin_q;
        end
    end

    // Stage-2 exact magnitude sum; start flushes anything in flight.
    always_comb begin
        s2_vld_d  = s1_vld_q & ~i_start_test;
        s2_good_d = s1_good_q & ~i_start_test;
        s2_bad_d  = s1_bad_q & ~i_start_test;
        s2_bin_d  = s1_bin_q;
        s2_mag_d  = {1'b0, s1_re_q} + {1'b0, s1_im_q};
    end

    // Running peak tracker; a frame end snapshots it into res_* and re-arms it.
    always_comb begin
        cand_upd_s = s2_vld_q && !((PEAK_SKIP_DC != 0) && (s2_bin_q == BIN_ZERO))
                     && (s2_mag_q > trk_mag_q);
        trk_bin_d  = cand_upd_s ? s2_bin_q : trk_bin_q;
        trk_mag_d  = cand_upd_s ? s2_mag_q : trk_mag_q;
        res_bin_d  = res_bin_q;
        res_mag_d  = res_mag_q;
        cmt_d      = 1'b0;
        if (i_start_test) begin
            trk_bin_d = PEAK_INIT;
            trk_mag_d = '0;
        end else if (s2_vld_q && (s2_good_q || s2_bad_q)) begin
            res_bin_d = trk_bin_d;
            res_mag_d = trk_mag_d;
            cmt_d     = s2_good_q;
            trk_bin_d = PEAK_INIT;
            trk_mag_d = '0;
        end else begin
            cmt_d = 1'b0;
        end
    end

    // Test FSM and commit of a good frame one cycle after its last RAM write.
    always_comb begin
        state_d    = state_q;
        bank_d     = bank_q;
        peak_bin_d = peak_bin_q;
        peak_mag_d = peak_mag_q;
        frm_cnt_d  = frm_cnt_q;
        fin_d      = 1'b0;
        if (i_start_test) begin
            state_d   = ST_RUN;
            frm_cnt_d = '0;
        end else if (cmt_q && (state_q == ST_RUN)) begin
            bank_d     = ~bank_q;
            peak_bin_d = res_bin_q;
            peak_mag_d = res_mag_q;
            if (frm_cnt_q < FRM_TGT) begin
                frm_cnt_d = frm_cnt_q + CNT_ONE;
            end else begin
                frm_cnt_d = frm_cnt_q;
            end
            if (frm_cnt_d == FRM_TGT) begin
                fin_d   = 1'b1;
                state_d = ST_DONE;
            end else begin
                fin_d = 1'b0;
            end
        end else begin
            state_d = state_q;
        end
        tready_d = (state_d == ST_RUN);
    end

    // The commit edge already belongs to the next frame's bank.
    assign wr_bank_s = ~(bank_q ^ cmt_q);
    assign we_s      = i_aclken & s2_vld_q & ~i_start_test & ~i_areset;

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            state_q    <= ST_IDLE;
            tready_q   <= 1'b0;
            bin_q      <= '0;
            err_q      <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_good_q  <= 1'b0;
            s1_bad_q   <= 1'b0;
            s1_re_q    <= '0;
            s1_im_q    <= '0;
            s1_bin_q   <= '0;
            s2_vld_q   <= 1'b0;
            s2_good_q  <= 1'b0;
            s2_bad_q   <= 1'b0;
            s2_mag_q   <= '0;
            s2_bin_q   <= '0;
            trk_bin_q  <= PEAK_INIT;
            trk_mag_q  <= '0;
            res_bin_q  <= '0;
            res_mag_q  <= '0;
            cmt_q      <= 1'b0;
            bank_q     <= 1'b0;
            fin_q      <= 1'b0;
            peak_bin_q <= '0;
            peak_mag_q <= '0;
            frm_cnt_q  <= '0;
        end else if (i_aclken) begin
            state_q    <= state_d;
            tready_q   <= tready_d;
            bin_q      <= bin_d;
            err_q      <= err_d;
            s1_vld_q   <= s1_vld_d;
            s1_good_q  <= s1_good_d;
            s1_bad_q   <= s1_bad_d;
            s1_re_q    <= s1_re_d;
            s1_im_q    <= s1_im_d;
            s1_bin_q   <= s1_bin_d;
            s2_vld_q   <= s2_vld_d;
            s2_good_q  <= s2_good_d;
            s2_bad_q   <= s2_bad_d;
            s2_mag_q   <= s2_mag_d;
            s2_bin_q   <= s2_bin_d;
            trk_bin_q  <= trk_bin_d;
            trk_mag_q  <= trk_mag_d;
            res_bin_q  <= res_bin_d;
            res_mag_q  <= res_mag_d;
            cmt_q      <= cmt_d;
            bank_q     <= bank_d;
            fin_q      <= fin_d;
            peak_bin_q <= peak_bin_d;
            peak_mag_q <= peak_mag_d;
            frm_cnt_q  <= frm_cnt_d;
        end
    end

    ipsxe_fft_spectrum_dpram #(
        .ADDR_WIDTH (LOG2_FFT_LEN + 1),
        .DATA_WIDTH (MAG_WIDTH)
    ) u_dpram (
        .i_clk   (i_aclk),
        .i_rst   (i_areset),
        .i_we    (we_s),
        .i_waddr ({wr_bank_s, s2_bin_q}),
        .i_wdata (s2_mag_q),
        .i_raddr ({bank_q, i_rd_addr}),
        .o_rdata (o_rd_data)
    );

    assign o_axi4s_data_tready = tready_q;
    assign o_chk_finished      = fin_q;
    assign o_frame_err         = err_q;
    assign o_frm_cnt           = frm_cnt_q;
    assign o_bank_sel          = bank_q;
    assign o_peak_bin          = peak_bin_q;
    assign o_peak_mag          = peak_mag_q;

endmodule

// File: tb/tb_ipsxe_fft_spectrum_chk.sv
// Bench for ipsxe_fft_spectrum_chk with N=16: directed frames, expected
// commits queued at stimulus time and checked by a bank-toggle monitor.
module tb_ipsxe_fft_spectrum_chk;

    logic        clk = 1'b0;
    logic        rst, aclken, tvalid, tlast, start;
    logic [31:0] tdata;
    logic [3:0]  rd_addr;
    logic        tready, fin, ferr, bank;
    logic [3:0]  frm_cnt, peak_bin;
    logic [16:0] rd_data, peak_mag;

    ipsxe_fft_spectrum_chk #(.LOG2_FFT_LEN(4)) dut (
        .i_aclk              (clk),
        .i_areset            (rst),
        .i_aclken            (aclken),
        .o_axi4s_data_tready (tready),
        .i_axi4s_data_tvalid (tvalid),
        .i_axi4s_data_tdata  (tdata),
        .i_axi4s_data_tlast  (tlast),
        .i_start_test        (start),
        .o_chk_finished      (fin),
        .o_frame_err         (ferr),
        .o_frm_cnt           (frm_cnt),
        .o_bank_sel          (bank),
        .i_rd_addr           (rd_addr),
        .o_rd_data           (rd_data),
        .o_peak_bin          (peak_bin),
        .o_peak_mag          (peak_mag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int bnk;
        int pbin;
        int pmag;
        int fin;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   exp_frm = 0;
    int   fin_pulses = 0;
    logic exp_bank = 1'b0;
    logic prev_bank = 1'b0;
    int   bin_re[16];
    int   bin_im[16];

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_commit(input int pbin, input int pmag, input int f);
        exp_t e;
        exp_frm++;
        exp_bank = ~exp_bank;
        e.cnt  = exp_frm;
        e.bnk  = int'(exp_bank);
        e.pbin = pbin;
        e.pmag = pmag;
        e.fin  = f;
        sb_q.push_back(e);
    endtask

    task automatic send_beats(input int n, input int last_idx);
        logic [15:0] r, m;
        for (int i = 0; i < n; i++) begin
            r      = bin_re[i][15:0];
            m      = bin_im[i][15:0];
            tvalid = 1'b1;
            tdata  = {m, r};
            tlast  = (i == last_idx);
            @(posedge clk);
            #1;
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        exp_frm = 0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (sb_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d commits still pending, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 16; i++) begin
            bin_re[i] = i;
            bin_im[i] = 0;
        end
    endtask

    // Monitor: every bank toggle is a commit and must match the queue head.
    always @(negedge clk) begin
        if (rst) begin
            prev_bank = 1'b0;
        end else begin
            if (fin) fin_pulses++;
            if (bank !== prev_bank) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_commit: bank %0d frm_cnt %0d, required no commit", bank, frm_cnt);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("frm_cnt", frm_cnt, mon_e.cnt);
                    chk("bank_sel", bank, mon_e.bnk);
                    chk("peak_bin", peak_bin, mon_e.pbin);
                    chk("peak_mag", peak_mag, mon_e.pmag);
                    chk("finished_at_commit", fin, mon_e.fin);
                end
            end
            prev_bank = bank;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; aclken = 1'b1; tvalid = 1'b0; tlast = 1'b0;
        tdata = 32'd0; start = 1'b0; rd_addr = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tready", tready, 0);
        chk("rst_finished", fin, 0);
        chk("rst_frame_err", ferr, 0);
        chk("rst_frm_cnt", frm_cnt, 0);
        chk("rst_bank", bank, 0);
        chk("rst_peak_bin", peak_bin, 0);
        chk("rst_peak_mag", peak_mag, 0);
        chk("rst_rd_data", rd_data, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Ten ramp frames: peak is bin 15, finish on the tenth commit.
        do_start();
        chk("run_tready", tready, 1);
        fill_ramp();
        for (int f = 0; f < 10; f++) begin
            expect_commit(15, 15, (f == 9) ? 1 : 0);
            send_beats(16, 15);
        end
        drain();
        repeat (4) @(posedge clk);
        #1;
        chk("done_tready", tready, 0);
        chk("done_frm_cnt", frm_cnt, 10);
        chk("finished_pulses", fin_pulses, 1);
        rd_addr = 4'd7;
        @(posedge clk);
        #1;
        chk("rd_bin7", rd_data, 7);

        // Full-scale negative bin 3 gives an exact 65536 magnitude.
        do_start();
        chk("start_frm_cnt", frm_cnt, 0);
        chk("start_tready", tready, 1);
        for (int i = 0; i < 16; i++) begin
            bin_re[i] = 1;
            bin_im[i] = 0;
        end
        bin_re[3] = -32768;
        bin_im[3] = -32768;
        expect_commit(3, 65536, 0);
        send_beats(16, 15);
        drain();
        rd_addr = 4'd3;
        @(posedge clk);
        #1;
        chk("rd_bin3", rd_data, 65536);
        rd_addr = 4'd4;
        @(posedge clk);
        #1;
        chk("rd_bin4", rd_data, 1);

        // Early tlast at bin 9: error, no commit, next frame fine.
        for (int i = 0; i < 16; i++) begin
            bin_re[i] = 2;
            bin_im[i] = 0;
        end
        send_beats(10, 9);
        repeat (5) @(posedge clk);
        #1;
        chk("early_err", ferr, 1);
        chk("early_bank", bank, exp_bank);
        chk("early_frm_cnt", frm_cnt, 1);
        expect_commit(1, 2, 0);
        send_beats(16, 15);
        drain();
        chk("err_sticky", ferr, 1);

        // Missing tlast, then a good frame; bin 0 largest but DC is skipped.
        do_start();
        chk("start_err_clr", ferr, 0);
        for (int i = 0; i < 16; i++) begin
            bin_re[i] = -5;
            bin_im[i] = 0;
        end
        bin_re[0] = 500;
        bin_re[2] = 100;
        bin_re[6] = 0;
        bin_im[6] = -100;
        send_beats(16, -1);
        repeat (5) @(posedge clk);
        #1;
        chk("missing_err", ferr, 1);
        chk("missing_frm_cnt", frm_cnt, 0);
        chk("missing_bank", bank, exp_bank);
        expect_commit(2, 100, 0);
        send_beats(16, 15);
        drain();

        // Start during frame 3 discards the partial frame.
        do_start();
        fill_ramp();
        expect_commit(15, 15, 0);
        send_beats(16, 15);
        expect_commit(15, 15, 0);
        send_beats(16, 15);
        drain();
        chk("pre_abort_frm_cnt", frm_cnt, 2);
        send_beats(5, -1);
        do_start();
        chk("abort_frm_cnt", frm_cnt, 0);
        chk("abort_err", ferr, 0);
        repeat (6) @(posedge clk);
        #1;
        chk("abort_bank", bank, exp_bank);
        expect_commit(15, 15, 0);
        send_beats(16, 15);
        drain();
        chk("after_abort_frm_cnt", frm_cnt, 1);
        chk("after_abort_err", ferr, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
